// File: rtl/mips_instr_encoder.sv
// Field-level MIPS instruction encoder. It writes the encoded words one after another into instruction memory.
// Define LI_COMPACT_EN to emit LI as a single word when either 16-bit half of the immediate is zero.
module mips_instr_encoder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_kind,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [31:0]   req_imm,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          full,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  typedef enum logic [3:0] {
    K_NOP, K_ADDU, K_SUBU, K_OR, K_ORI, K_LUI, K_LW, K_SW,
    K_LH, K_BEQ, K_J, K_JAL, K_JR, K_LI
  } kind_t;

  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;

  state_t        state, state_next;
  logic          we_q;
  logic          need_second;
  logic [31:0]   second_word;
  logic [31:0]   word1, word2;
  logic          two_word, illegal, accept, at_last;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] func);
    return {6'b000000, rs, rt, rd, 5'b00000, func};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    word1    = '0;
    word2    = '0;
    two_word = 1'b0;
    illegal  = 1'b0;
    case (kind_t'(req_kind))
      K_NOP:  word1 = '0;
      K_ADDU: word1 = rtype(req_rs, req_rt, req_rd, 6'b100001);
      K_SUBU: word1 = rtype(req_rs, req_rt, req_rd, 6'b100011);
      K_OR:   word1 = rtype(req_rs, req_rt, req_rd, 6'b100101);
      K_JR:   word1 = rtype(req_rs, 5'd0, 5'd0, 6'b001000);
      K_ORI:  word1 = itype(OP_ORI, req_rs, req_rt, req_imm[15:0]);
      K_LUI:  word1 = itype(OP_LUI, 5'd0, req_rt, req_imm[15:0]);
      K_LW:   word1 = itype(6'b100011, req_rs, req_rt, req_imm[15:0]);
      K_SW:   word1 = itype(6'b101011, req_rs, req_rt, req_imm[15:0]);
      K_LH:   word1 = itype(6'b100001, req_rs, req_rt, req_imm[15:0]);
      K_BEQ:  word1 = itype(6'b000100, req_rs, req_rt, req_imm[15:0]);
      K_J:    word1 = {6'b000010, req_imm[25:0]};
      K_JAL:  word1 = {6'b000011, req_imm[25:0]};
      K_LI: begin
`ifdef LI_COMPACT_EN
        if (req_imm[31:16] == 16'd0) begin
          word1 = itype(OP_ORI, 5'd0, req_rt, req_imm[15:0]);
        end else if (req_imm[15:0] == 16'd0) begin
          word1 = itype(OP_LUI, 5'd0, req_rt, req_imm[31:16]);
        end else begin
          two_word = 1'b1;
          word1    = itype(OP_LUI, 5'd0, req_rt, req_imm[31:16]);
          word2    = itype(OP_ORI, req_rt, req_rt, req_imm[15:0]);
        end
`else
        two_word = 1'b1;
        word1    = itype(OP_LUI, 5'd0, req_rt, req_imm[31:16]);
        word2    = itype(OP_ORI, req_rt, req_rt, req_imm[15:0]);
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

  // im_addr is the write pointer itself. A two-word LI must not start on the last word.
  assign at_last   = (im_addr == AW'(DEPTH - 1));
  assign req_ready = (state == IDLE) && !full && !clear && !(two_word && at_last);
  assign accept    = req_valid && req_ready;

  // clear gates the strobe in the same cycle, so an aborted emission never writes.
  assign im_we = we_q && !clear;

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && !illegal) state_next = EMIT1;
        EMIT1:   state_next = need_second ? EMIT2 : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      full        <= 1'b0;
      err         <= 1'b0;
      need_second <= 1'b0;
      second_word <= '0;
    end else begin
      state <= state_next;
      err   <= 1'b0;
      if (clear) begin
        we_q    <= 1'b0;
        im_addr <= '0;
        full    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (illegal) begin
                err <= 1'b1;
              end else begin
                we_q        <= 1'b1;
                im_wdata    <= word1;
                second_word <= word2;
                need_second <= two_word;
              end
            end
          end
          default: begin
            // The current word commits at this edge. Advance the pointer and wrap at the end of memory.
            im_addr <= im_addr + AW'(1);
            if (at_last) full <= 1'b1;
            if (state == EMIT1 && need_second) begin
              im_wdata <= second_word;
            end else begin
              we_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder. Expected IM writes are queued on each accepted request
// and checked by a monitor on the falling edge.
module tb_mips_instr_encoder;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_kind = '0;
  logic [4:0]    req_rs = '0, req_rt = '0, req_rd = '0;
  logic [31:0]   req_imm = '0;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          full;
  logic          err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           sb[$];
  wr_t           exp_wr;
  logic [AW-1:0] exp_ptr = '0;
  int            errors = 0;
  int            checks = 0;

  mips_instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && im_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%08h (no write expected)", im_addr, im_wdata);
      end else begin
        exp_wr = sb.pop_front();
        if (im_addr !== exp_wr.addr || im_wdata !== exp_wr.data) begin
          errors++;
          $display("FAIL im_write got addr=%0h data=%08h expected addr=%0h data=%08h",
                   im_addr, im_wdata, exp_wr.addr, exp_wr.data);
        end
      end
    end
  end

  task automatic expect_word(input logic [31:0] w);
    sb.push_back('{addr: exp_ptr, data: w});
    exp_ptr = exp_ptr + AW'(1);
  endtask

  // Present a request and wait for the handshake. Returns at posedge+1 with req_valid dropped.
  task automatic handshake(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                           input logic [31:0] imm, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout kind=%0d req_ready=%b expected 1", k, req_ready);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] rs, rt, rd, input logic [31:0] imm,
                      input int n, input logic [31:0] w1, input logic [31:0] w2);
    bit ok;
    handshake(k, rs, rt, rd, imm, ok);
    if (ok && n >= 1) expect_word(w1);
    if (ok && n >= 2) expect_word(w2);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !im_we) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain pending=%0d im_we=%b expected 0 pending", name, sb.size(), im_we);
      sb.delete();
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({im_we, im_addr, im_wdata, full, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs we=%b addr=%0h data=%08h full=%b err=%b expected all 0",
               im_we, im_addr, im_wdata, full, err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_ptr = '0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b expected 1", req_ready);
    end
  endtask

  task automatic test_back_to_back;
    send(4'd1, 5'd1, 5'd2, 5'd3, 32'h0, 1, 32'h00221821, 32'h0);
    send(4'd4, 5'd0, 5'd5, 5'd0, 32'h0000_1234, 1, 32'h34051234, 32'h0);
    wait_idle("back_to_back");
    checks++;
    if (im_addr !== AW'(2) || im_wdata !== 32'h34051234) begin
      errors++;
      $display("FAIL idle_hold addr=%0h data=%08h expected addr=2 data=34051234", im_addr, im_wdata);
    end
  endtask

  task automatic test_li;
    send(4'd13, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 2, 32'h3C081234, 32'h35085678);
    checks++;
    if (req_ready !== 1'b0 || im_we !== 1'b1) begin
      errors++;
      $display("FAIL li_emit1 ready=%b we=%b expected ready=0 we=1", req_ready, im_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || im_we !== 1'b1) begin
      errors++;
      $display("FAIL li_emit2 ready=%b we=%b expected ready=0 we=1", req_ready, im_we);
    end
    wait_idle("li");
`ifdef LI_COMPACT_EN
    send(4'd13, 5'd0, 5'd8, 5'd0, 32'h0000_1234, 1, 32'h34081234, 32'h0);
`else
    send(4'd13, 5'd0, 5'd8, 5'd0, 32'h0000_1234, 2, 32'h3C080000, 32'h35081234);
`endif
    wait_idle("li_small");
  endtask

  task automatic test_encodings;
    send(4'd9,  5'd1,  5'd2, 5'd0, 32'h0000_FFFF, 1, 32'h1022FFFF, 32'h0);
    send(4'd11, 5'd0,  5'd0, 5'd0, 32'h0000_0C00, 1, 32'h0C000C00, 32'h0);
    send(4'd12, 5'd31, 5'd7, 5'd9, 32'h0,         1, 32'h03E00008, 32'h0);
    send(4'd8,  5'd29, 5'd4, 5'd0, 32'h0000_0008, 1, 32'h87A40008, 32'h0);
    send(4'd7,  5'd29, 5'd4, 5'd0, 32'h0000_FFFC, 1, 32'hAFA4FFFC, 32'h0);
    send(4'd6,  5'd29, 5'd4, 5'd0, 32'hFFFF_0008, 1, 32'h8FA40008, 32'h0);
    send(4'd5,  5'd3,  5'd9, 5'd0, 32'h0000_ABCD, 1, 32'h3C09ABCD, 32'h0);
    send(4'd2,  5'd1,  5'd2, 5'd3, 32'h0,         1, 32'h00221823, 32'h0);
    send(4'd3,  5'd1,  5'd2, 5'd3, 32'h0,         1, 32'h00221825, 32'h0);
    send(4'd10, 5'd0,  5'd0, 5'd0, 32'hFFFF_FFFF, 1, 32'h0BFFFFFF, 32'h0);
    send(4'd0,  5'd7,  5'd7, 5'd7, 32'hFFFF_FFFF, 1, 32'h00000000, 32'h0);
    wait_idle("encodings");
  endtask

  task automatic test_illegal;
    for (int k = 14; k <= 15; k++) begin
      send(4'(k), 5'd1, 5'd2, 5'd3, 32'h0, 0, 32'h0, 32'h0);
      checks++;
      if (err !== 1'b1 || im_we !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse kind=%0d err=%b we=%b expected err=1 we=0", k, err, im_we);
      end
      @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b0 || im_addr !== exp_ptr) begin
        errors++;
        $display("FAIL illegal_after kind=%0d err=%b addr=%0h expected err=0 addr=%0h",
                 k, err, im_addr, exp_ptr);
      end
    end
  endtask

  task automatic test_fill;
    while (exp_ptr != AW'(DEPTH - 1)) send(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1, 32'h0, 32'h0);
    wait_idle("fill");
    @(negedge clk);
    req_kind = 4'd13; req_rt = 5'd8; req_imm = 32'h1234_5678; req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || im_addr !== AW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL li_at_last ready=%b addr=%0h expected ready=0 addr=3ff", req_ready, im_addr);
    end
    @(negedge clk);
    req_valid = 1'b0;
    send(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1, 32'h0, 32'h0);
    wait_idle("last_word");
    checks++;
    if (full !== 1'b1 || im_addr !== '0) begin
      errors++;
      $display("FAIL full_set full=%b addr=%0h expected full=1 addr=0", full, im_addr);
    end
    req_kind = 4'd0; req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b expected 0", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    clear = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready got %b expected 0", req_ready);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    checks++;
    if (full !== 1'b0 || im_addr !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_state full=%b addr=%0h ready=%b expected 0 0 1", full, im_addr, req_ready);
    end
    exp_ptr = '0;
    send(4'd1, 5'd4, 5'd5, 5'd6, 32'h0, 1, 32'h00853021, 32'h0);
    wait_idle("after_clear");
  endtask

  task automatic test_abort;
    bit ok;
    handshake(4'd13, 5'd0, 5'd9, 5'd0, 32'hCAFE_BABE, ok);
    reset_n = 1'b0;
    #1;
    checks++;
    if (im_we !== 1'b0 || im_addr !== '0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort we=%b addr=%0h full=%b expected 0 0 0", im_we, im_addr, full);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_ptr = '0;
    send(4'd4, 5'd2, 5'd3, 5'd0, 32'h0000_00FF, 1, 32'h344300FF, 32'h0);
    wait_idle("after_reset");

    handshake(4'd13, 5'd0, 5'd9, 5'd0, 32'hCAFE_BABE, ok);
    if (ok) expect_word(32'h3C09CAFE);
    @(posedge clk);
    #1;
    clear = 1'b1;
    #1;
    checks++;
    if (im_we !== 1'b0) begin
      errors++;
      $display("FAIL clear_abort_we got %b expected 0", im_we);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_ptr = '0;
    wait_idle("clear_abort");
    checks++;
    if (im_addr !== '0 || full !== 1'b0) begin
      errors++;
      $display("FAIL clear_abort_state addr=%0h full=%b expected 0 0", im_addr, full);
    end
    send(4'd12, 5'd31, 5'd0, 5'd0, 32'h0, 1, 32'h03E00008, 32'h0);
    wait_idle("after_clear_abort");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_li();
    test_encodings();
    test_illegal();
    test_fill();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the single-cycle CPU's instruction decoder: turns field-level instruction requests into 32-bit MIPS words and writes them sequentially into instruction memory.
- Used by the test/boot loader path to build programs in IM without an external assembler.
- Supports the CPU's instruction subset plus the pseudo-op LI, which expands to lui + ori.

Parameters:
- DEPTH, 1024, IM size in words.
- AW, 10, IM word-address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart: address returns to 0 and the full flag clears.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_kind  in  4  instruction kind: 0 NOP, 1 ADDU, 2 SUBU, 3 OR, 4 ORI, 5 LUI, 6 LW, 7 SW, 8 LH, 9 BEQ, 10 J, 11 JAL, 12 JR, 13 LI; 14–15 illegal.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  32  immediate: LI uses all 32 bits; I-type kinds use [15:0]; J/JAL use [25:0] as the target.
- im_we  out  1  IM write strobe.
- im_addr  out  AW  IM word address.
- im_wdata  out  32  encoded instruction.
- full  out  1  last IM word has been written.
- err  out  1  one-cycle pulse: an illegal kind was accepted.

Behaviour:
- Reset values: im_we=0, im_addr=0, im_wdata=0, full=0, err=0, state IDLE. Reset takes effect immediately, including mid-emission; no partial write occurs after reset.
- Encoding formats:
  - R-type: {6'b0, rs, rt, rd, 5'b0, func}, with func ADDU 100001, SUBU 100011, OR 100101, JR 001000. JR forces rt=rd=0.
  - I-type: {op, rs, rt, imm[15:0]}, with op ORI 001101, LUI 001111 (rs forced 0), LW 100011, SW 101011, LH 100001, BEQ 000100.
  - J-type: {op, imm[25:0]}, with op J 000010, JAL 000011.
  - NOP: 32'h0.
- States:
  - IDLE: req_ready=1 unless full, or unless the kind needs 2 words and im_addr==DEPTH-1.
  - EMIT1: entered on the accepting handshake (req_valid && req_ready); request fields are captured.
  - EMIT2: used only by LI.
- Latency: im_we is high during the cycle after acceptance, with im_addr = the current write pointer.
  - Single-word kinds: EMIT1 -> IDLE. Throughput is 1 request per 2 cycles.
  - LI rt,imm: EMIT1 writes lui rt,imm[31:16]; EMIT2 writes ori rt,rt,imm[15:0] at the next address; then IDLE.
- Write pointer: increments after each write. A write at DEPTH-1 sets full and wraps the pointer to 0. While full, req_ready=0 until clear or reset.
- Illegal kind: the request is accepted, no write occurs, err pulses during the following cycle, and the state stays IDLE.
- clear has priority over everything:
  - In EMIT1/EMIT2 it aborts the emission with no write that cycle and returns to IDLE.
  - It sets the pointer to 0 and full to 0.
  - A request presented the same cycle as clear is not accepted (req_ready=0 while clear=1).
- Outputs change only on the clock edge. im_wdata holds its last value when im_we=0.

Optional Feature:
- Macro: LI_COMPACT_EN.
- Defined:
  - LI with imm[31:16]==0 emits one word, ori rt,$0,imm[15:0].
  - LI with imm[15:0]==0 emits one word, lui rt,imm[31:16].
  - All other LI values emit two words as normal.
  - The 2-word ready check applies only when both halves are nonzero.
- Undefined: LI always emits two words.

Test Plan:
- Reset, then ADDU rs=1 rt=2 rd=3 -> one cycle later im_we=1, im_addr=0, im_wdata=32'h00221821; then ORI rs=0 rt=5 imm=16'h1234 -> addr 1, 32'h34051234.
- LI rt=8 imm=32'h12345678 -> two consecutive writes: 32'h3C081234 then 32'h35085678; req_ready is low during both; LI imm=32'h00001234 writes 32'h34081234 (one word) with LI_COMPACT_EN, two words without.
- BEQ rs=1 rt=2 imm=16'hFFFF -> 32'h1022FFFF; JAL imm=26'h0000C00 -> 32'h0C000C00; JR rs=31 -> 32'h03E00008; LH rs=29 rt=4 imm=8 -> 32'h87A40008; SW rs=29 rt=4 imm=16'hFFFC -> 32'hAFA4FFFC.
- req_kind=15 -> no im_we, err=1 for exactly one cycle, write pointer unchanged.
- Fill to DEPTH-1, then present LI -> req_ready=0; present NOP -> written at DEPTH-1, full=1, pointer wraps to 0, req_ready stays 0; assert clear -> full=0, next write lands at address 0.
- Assert reset low during LI EMIT1, and separately assert clear during EMIT2 -> no further im_we, im_addr=0 on return, and the encoder accepts a new request.
